// File: rtl/lc3_pkg.sv
// Shared widths, types and FSM state encoding for the LC3 register-file sequencer.
package lc3_pkg;
    localparam int DATA_W   = 16;
    localparam int SEL_W    = 3;
    localparam int NUM_REGS = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_B,
        RESP
    } regfile_seq_state_t;
endpackage

// File: rtl/regfile_seq_regfile.sv
// LC3 8x16 single-port register file: one select for both the read and the write path.
module regfile
    import lc3_pkg::*;
(
    input  logic              clk,
    input  logic              write_en,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data
);
    // Contents are deliberately not reset; software must write before reading.
    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (write_en) begin
            regs[sel] <= in_data;
        end
    end

    assign out_data = regs[sel];
endmodule

// File: rtl/regfile_seq.sv
// Sequencer sharing the single register-file port between a two-operand reader and a writer.
// Define REGFILE_SEQ_FAIR_EN for alternating read/write priority; default is strict write priority.
module regfile_seq
    import lc3_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [SEL_W-1:0]  rd_sr1,
    input  logic [SEL_W-1:0]  rd_sr2,
    input  logic              rd_two,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_a,
    output logic [DATA_W-1:0] res_b,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [SEL_W-1:0]  wr_dr,
    input  logic [DATA_W-1:0] wr_data
);
    regfile_seq_state_t state;
    logic [SEL_W-1:0]   sr2_q;
    logic               read_wins;
    logic               wr_grant;
    logic               rd_accept;
    logic [SEL_W-1:0]   rf_sel;
    logic [DATA_W-1:0]  rf_out;

`ifdef REGFILE_SEQ_FAIR_EN
    logic fair_q;
    logic contended;

    assign contended = (state == IDLE) && rd_valid && wr_valid;
    assign read_wins = contended && fair_q;

    // Remembers that the writer won the last tie so the reader gets the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fair_q <= 1'b0;
        end else if (rd_accept) begin
            fair_q <= 1'b0;
        end else if (contended && wr_grant) begin
            fair_q <= 1'b1;
        end
    end
`else
    assign read_wins = 1'b0;
`endif

    // The write may use the port in IDLE or RESP; RD_B owns it for the second operand.
    always_comb begin
        wr_grant  = rst_n && wr_valid && (state != RD_B) && !read_wins;
        rd_accept = rst_n && rd_valid && (state == IDLE) && !wr_grant;
        if (wr_grant) begin
            rf_sel = wr_dr;
        end else if (state == RD_B) begin
            rf_sel = sr2_q;
        end else begin
            rf_sel = rd_sr1;
        end
    end

    assign rd_ready = rd_accept;
    assign wr_ready = wr_grant;

    regfile u_regfile (
        .clk      (clk),
        .write_en (wr_grant),
        .sel      (rf_sel),
        .in_data  (wr_data),
        .out_data (rf_out)
    );

    // Operands are snapshotted so later writes never disturb a pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_a     <= '0;
            res_b     <= '0;
            sr2_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_accept) begin
                        res_a <= rf_out;
                        sr2_q <= rd_sr2;
                        if (rd_two) begin
                            state <= RD_B;
                        end else begin
                            res_b     <= '0;
                            res_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RD_B: begin
                    res_b     <= rf_out;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/regfile_seq.md
# regfile_seq

Access sequencer for the LC3 8×16-bit single-port register file. It gives a two-operand read requester and a write requester shared use of the one `sel`/`write_en` port. Each side uses a valid/ready handshake, and the block holds an operand snapshot until the consumer takes it. It sits between decode/writeback and the register file, which it instantiates internally.

## Interface
Parameters:
- none; widths are fixed by the package (16-bit data, 3-bit register select).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rd_valid`  in  1  read request present.
- `rd_ready`  out  1  read request accepted this cycle.
- `rd_sr1`  in  3  first source register.
- `rd_sr2`  in  3  second source register.
- `rd_two`  in  1  1 = read both operands; 0 = read `rd_sr1` only.
- `res_valid`  out  1  operand result held.
- `res_ready`  in  1  consumer takes the result.
- `res_a`  out  16  value of SR1.
- `res_b`  out  16  value of SR2; 0 when `rd_two` = 0.
- `wr_valid`  in  1  write request present.
- `wr_ready`  out  1  write performed this cycle.
- `wr_dr`  in  3  destination register.
- `wr_data`  in  16  write data.

## Operation
- FSM states: IDLE, RD_B, RESP. Only one register-file access happens per cycle.
- **IDLE, write granted:** `wr_ready`=1 and file write_en=1 with sel=`wr_dr`. The data is visible to reads from the next cycle.
- **IDLE, read accepted:** happens when the write is not granted.
  - `rd_ready`=1 and sel=`rd_sr1`.
  - `res_a` and latched `rd_sr2`/`rd_two` are captured at the edge.
  - Next state is RD_B if `rd_two`=1, otherwise RESP with `res_b`=0.
- **IDLE, contention** (`rd_valid`&`wr_valid`): the write wins. The read is accepted on a later IDLE cycle. See Configuration.
- **RD_B:** sel = latched SR2, `res_b` captured, go to RESP. No grants are given in this state.
- **RESP:**
  - `res_valid`=1; `res_a`/`res_b` stay stable until `res_ready`.
  - `res_valid`&`res_ready` returns to IDLE.
  - A write may be granted in RESP because the port is free. It does not alter the captured operands (snapshot semantics).
  - `rd_ready`=0 in RESP; a read is never accepted the same cycle a response leaves.
- `wr_ready` and `rd_ready` are combinational from state and inputs. Requesters must hold their request fields stable while valid is high and ready is low.
- Register contents are not reset. A read before any write returns X.

## Timing
- Reset values: state IDLE, `res_valid`=0, `res_a`=`res_b`=0, fairness flag=0. `rd_ready`/`wr_ready` are 0 while `rst_n`=0.
- Two-operand read: accept at cycle 0, RD_B at cycle 1, `res_valid` at cycle 2.
- One-operand read: `res_valid` at cycle 1.
- Write: completes in its grant cycle (zero wait when uncontended).
- Back-to-back reads: 3-cycle period (2 if single-operand and `res_ready` is held high).
- Reset mid-operation (RD_B or RESP): the captured request is discarded, no response is produced, and the FSM returns to IDLE immediately. An in-flight write grant has no effect unless its edge completed before reset.

## Configuration
- `REGFILE_SEQ_FAIR_EN` undefined: strict write priority. Continuous `wr_valid` starves reads.
- `REGFILE_SEQ_FAIR_EN` defined: alternating priority.
  - A one-bit flag is set when a write wins a contended IDLE cycle and cleared when a read is accepted.
  - While the flag is set, the read wins the next contended IDLE cycle.
  - A write can then wait at most one read sequence.

## Structure
- Package `lc3_pkg`: `DATA_W`=16, `SEL_W`=3, `regfile_seq_state_t` enum {IDLE, RD_B, RESP}.
- Sub-module: one existing `regfile` instance. The FSM drives its `sel`, `write_en` and `in_data`, and captures its `out_data`.

## Test plan
- Write R3=0x1234, R0=0xBEEF, then read sr1=3, sr2=0, two=1 → `res_valid` 2 cycles after accept, `res_a`=0x1234, `res_b`=0xBEEF.
- Single-operand read sr1=3 → `res_valid` 1 cycle after accept, `res_b`=0.
- `rd_valid` and `wr_valid` (R5=0x00AA) together in IDLE, reading sr1=5 → write granted first, read accepted next cycle, `res_a`=0x00AA.
- Hold `res_ready`=0 for 3 cycles in RESP while writing R3=0xFFFF → write completes, `res_a` stays 0x1234 until taken.
- `wr_valid` and `rd_valid` held high for 10 cycles:
  - Without `REGFILE_SEQ_FAIR_EN`: zero reads accepted.
  - With it: grants alternate write/read.
- Assert `rst_n`=0 in RD_B → `res_valid`=0 and state IDLE at once; after release, a new read completes normally.
